riscuva_irq_ctrl: RTL and testbench

// Prioritised interrupt controller for the 8-bit RISC core's single intReq/intAck pair.

---
 rtl/riscuva_irq_ctrl.sv | 86 ++++++++
 tb/tb_riscuva_irq_ctrl.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/riscuva_irq_ctrl.sv
// riscuva_irq_ctrl: prioritised interrupt controller driving the core's intReq/intAck pair
module riscuva_irq_ctrl #(
  parameter int NSRC = 8,
  parameter logic [7:0] BASE = 8'hF0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] irqSrc,
  input  logic [7:0]      portAddress,
  input  logic            portRead,
  input  logic            portWrite,
  input  logic [7:0]      portWData,
  output logic [7:0]      rdData,
  output logic            rdSel,
  output logic            intReq,
  input  logic            intAck
);
  typedef enum logic [1:0] {IDLE = 2'b00, REQ = 2'b01, ACT = 2'b10, DONE = 2'b11} state_t;
  localparam logic [7:0] VALID = 8'((9'd1 << NSRC) - 9'd1);
  state_t     state;
  logic [7:0] pend, mask, vector, src, src_prev, rise, active, win, w1c, ack_clr;
  logic       gie, ack_prev, ack_rise, sel, wr;
  logic [1:0] off;
  always_comb begin
    src = '0;
    src[NSRC-1:0] = irqSrc;
  end
  // 9-bit compare so a BASE near 8'hFF never wraps around to low addresses
  assign sel      = {1'b0, portAddress} >= {1'b0, BASE} && {1'b0, portAddress} <= {1'b0, BASE} + 9'd3;
  assign off      = 2'(portAddress - BASE);
  assign wr       = portWrite && sel;
  assign rdSel    = portRead && sel;
  assign rdData   = !rdSel ? 8'h00 : off == 2'd0 ? pend : off == 2'd1 ? mask :
                    off == 2'd2 ? vector : {state, 5'b0, gie};
  assign rise     = src & ~src_prev & VALID;
  assign active   = pend & mask;
  assign ack_rise = intAck && !ack_prev;
  assign w1c      = wr && off == 2'd0 ? portWData : 8'h00;
  always_comb begin
    win = 8'hFF;
    for (int i = 7; i >= 0; i--)
      if (active[i]) win = 8'(i);
  end
  assign ack_clr = state == REQ && ack_rise && win != 8'hFF ? 8'h01 << win[2:0] : 8'h00;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= IDLE;
      intReq   <= 1'b0;
      pend     <= '0;
      mask     <= '0;
      gie      <= 1'b0;
      vector   <= 8'hFF;
      src_prev <= '0;
      ack_prev <= 1'b0;
    end else begin
      src_prev <= src;
      ack_prev <= intAck;
      pend     <= (pend & ~w1c & ~ack_clr) | rise;
      if (wr && off == 2'd1) mask <= portWData & VALID;
      if (wr && off == 2'd3) gie <= portWData[0];
      case (state)
        IDLE, DONE:
          if (ack_rise) begin
            state  <= ACT;
            vector <= 8'hFF;
            intReq <= 1'b0;
          end else if (state == IDLE && gie && |active) begin
            state  <= REQ;
            intReq <= 1'b1;
          end else state <= IDLE;
        REQ:
          if (ack_rise) begin
            state  <= ACT;
            vector <= win;
            intReq <= 1'b0;
          end else if (!(gie && |active)) begin
            state  <= IDLE;
            intReq <= 1'b0;
          end
        default: begin
          intReq <= 1'b0;
          if (!intAck) state <= DONE;
        end
      endcase
    end
endmodule

// File: tb/tb_riscuva_irq_ctrl.sv
// tb_riscuva_irq_ctrl: directed checks of the interrupt controller
`timescale 1ns/100ps
module tb_riscuva_irq_ctrl;
  logic       clk = 0, reset = 1, portRead = 0, portWrite = 0, intAck = 0;
  logic [7:0] irqSrc = 0, portAddress = 0, portWData = 0;
  logic [7:0] rdData, d;
  logic       rdSel, intReq;
  int         n_checks = 0, n_errors = 0;
  riscuva_irq_ctrl #(.NSRC(8), .BASE(8'hF0)) dut (
    .clk(clk), .reset(reset), .irqSrc(irqSrc), .portAddress(portAddress),
    .portRead(portRead), .portWrite(portWrite), .portWData(portWData),
    .rdData(rdData), .rdSel(rdSel), .intReq(intReq), .intAck(intAck)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic rd(input logic [7:0] a, output logic [7:0] v);
    portAddress = a;
    portRead = 1;
    #1 v = rdData;
    portRead = 0;
  endtask
  task automatic wr(input logic [7:0] a, input logic [7:0] v);
    portAddress = a;
    portWData = v;
    portWrite = 1;
    tick();
    portWrite = 0;
  endtask
  task automatic chk_reg(input string tag, input logic [7:0] a, input logic [7:0] exp);
    rd(a, d);
    check(tag, d, exp);
  endtask
  initial begin
    tick(); tick();
    reset = 0;
    tick();
    chk_reg("rst_pend", 8'hF0, 8'h00);
    chk_reg("rst_mask", 8'hF1, 8'h00);
    chk_reg("rst_vec", 8'hF2, 8'hFF);
    chk_reg("rst_ctrl", 8'hF3, 8'h00);
    check("rst_intreq", 8'(intReq), 8'h00);
    // 1: single masked-in source
    wr(8'hF1, 8'h05);
    wr(8'hF3, 8'h01);
    irqSrc = 8'h04; tick();
    irqSrc = 8'h00;
    chk_reg("t1_pend", 8'hF0, 8'h04);
    check("t1_intreq_lat", 8'(intReq), 8'h00);
    tick();
    check("t1_intreq", 8'(intReq), 8'h01);
    chk_reg("t1_ctrl_req", 8'hF3, 8'h41);
    intAck = 1; tick();
    chk_reg("t1_vec", 8'hF2, 8'h02);
    chk_reg("t1_pend_clr", 8'hF0, 8'h00);
    check("t1_intreq_ack", 8'(intReq), 8'h00);
    chk_reg("t1_ctrl_act", 8'hF3, 8'h81);
    intAck = 0; tick(); tick();
    // 2: two simultaneous sources, priority and re-request
    wr(8'hF1, 8'hFF);
    irqSrc = 8'h22; tick();
    irqSrc = 8'h00; tick();
    check("t2_intreq", 8'(intReq), 8'h01);
    intAck = 1; tick();
    chk_reg("t2_vec1", 8'hF2, 8'h01);
    chk_reg("t2_pend", 8'hF0, 8'h20);
    intAck = 0; tick();
    chk_reg("t2_ctrl_done", 8'hF3, 8'hC1);
    check("t2_intreq_done", 8'(intReq), 8'h00);
    tick();
    check("t2_intreq_idle", 8'(intReq), 8'h00);
    tick();
    check("t2_intreq_again", 8'(intReq), 8'h01);
    intAck = 1; tick();
    chk_reg("t2_vec5", 8'hF2, 8'h05);
    intAck = 0; tick(); tick();
    // 3: mask removed while requesting
    irqSrc = 8'h04; tick();
    irqSrc = 8'h00; tick();
    check("t3_intreq", 8'(intReq), 8'h01);
    wr(8'hF1, 8'h00);
    tick();
    check("t3_intreq_drop", 8'(intReq), 8'h00);
    chk_reg("t3_ctrl", 8'hF3, 8'h01);
    chk_reg("t3_pend", 8'hF0, 8'h04);
    // 4: set beats W1C on the same bit
    irqSrc = 8'h08; tick();
    irqSrc = 8'h00; tick();
    chk_reg("t4_pend_pre", 8'hF0, 8'h0C);
    irqSrc = 8'h08;
    wr(8'hF0, 8'h08);
    irqSrc = 8'h00;
    chk_reg("t4_pend_set_wins", 8'hF0, 8'h0C);
    wr(8'hF0, 8'h08);
    chk_reg("t4_pend_w1c", 8'hF0, 8'h04);
    wr(8'hF4, 8'hFF);
    wr(8'hEF, 8'hFF);
    chk_reg("t4_mask_oob", 8'hF1, 8'h00);
    rd(8'hF4, d);
    check("t4_rddata_oob", d, 8'h00);
    portAddress = 8'hF4; portRead = 1; #1;
    check("t4_rdsel_oob", 8'(rdSel), 8'h00);
    portAddress = 8'hF3; #1;
    check("t4_rdsel_in", 8'(rdSel), 8'h01);
    portRead = 0;
    // 5: spurious acknowledge
    wr(8'hF0, 8'hFF);
    wr(8'hF3, 8'h00);
    intAck = 1; tick();
    chk_reg("t5_vec", 8'hF2, 8'hFF);
    chk_reg("t5_ctrl", 8'hF3, 8'h80);
    chk_reg("t5_pend", 8'hF0, 8'h00);
    // 6: asynchronous reset while active
    wr(8'hF1, 8'h0F);
    wr(8'hF3, 8'h01);
    irqSrc = 8'h11; tick();
    irqSrc = 8'h00; tick();
    chk_reg("t6_pend_pre", 8'hF0, 8'h11);
    reset = 1; #1;
    chk_reg("t6_pend", 8'hF0, 8'h00);
    chk_reg("t6_mask", 8'hF1, 8'h00);
    chk_reg("t6_vec", 8'hF2, 8'hFF);
    chk_reg("t6_ctrl", 8'hF3, 8'h00);
    check("t6_intreq", 8'(intReq), 8'h00);
    intAck = 0; tick();
    reset = 0; tick();
    check("t6_intreq_post", 8'(intReq), 8'h00);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
